// File: rtl/pred_raw_array.sv
// Predicated read-add-write over an array of N_ENTRIES state words.
// Three-stage pipeline with same-index forwarding from S3 into S2 capture.
module pred_raw_array #(
    parameter int W         = 32,
    parameter int N_ENTRIES = 16,
    parameter int IDX_W     = $clog2(N_ENTRIES),
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [W-1:0]     pkt_1,
    input  logic [W-1:0]     pkt_2,
    input  logic [W-1:0]     cons_1,
    input  logic [W-1:0]     cons_2,
    input  logic             sel_1,
    input  logic             sel_3,
    input  logic [1:0]       sel_2,
    input  logic [1:0]       sel_4,
    input  logic [1:0]       rel_opcode,
    output logic             out_valid,
    output logic [IDX_W-1:0] o__idx,
    output logic [W-1:0]     o__read,
    output logic [W-1:0]     o__write,
    output logic             o__oor
);

    typedef enum logic [1:0] {
        REL_NE = 2'd0,
        REL_LT = 2'd1,
        REL_GT = 2'd2,
        REL_EQ = 2'd3
    } rel_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [W-1:0]     pkt_1;
        logic [W-1:0]     pkt_2;
        logic [W-1:0]     cons_1;
        logic [W-1:0]     cons_2;
        logic             sel_1;
        logic             sel_3;
        logic [1:0]       sel_2;
        logic [1:0]       sel_4;
        rel_e             rel;
    } pkt_t;

    // One extra bit so N_ENTRIES == 2**IDX_W is representable.
    localparam logic [IDX_W:0] LP_N = (IDX_W + 1)'(N_ENTRIES);

    logic [W-1:0] r_mem [N_ENTRIES];

    pkt_t         w_in_pkt;
    pkt_t         r_s1;
    logic         r_s1_valid;
    pkt_t         r_s2;
    logic         r_s2_valid;
    logic         r_s2_oor;
    logic [W-1:0] r_s2_state;

    logic         w_s1_oor;
    logic         w_s1_fwd;
    logic [W-1:0] w_s1_state;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_op1;
    logic [W-1:0] w_op2;
    logic         w_pred;
    logic [W:0]   w_sum;
    logic [W-1:0] w_add;
    logic [W-1:0] w_s3_read;
    logic [W-1:0] w_s3_write;

    assign w_in_pkt = '{
        idx:    in_idx,
        pkt_1:  pkt_1,
        pkt_2:  pkt_2,
        cons_1: cons_1,
        cons_2: cons_2,
        sel_1:  sel_1,
        sel_3:  sel_3,
        sel_2:  sel_2,
        sel_4:  sel_4,
        rel:    rel_e'(rel_opcode)
    };

    // S2 read: the packet now in S3 writes on the same edge, so bypass the array.
    assign w_s1_oor = ({1'b0, r_s1.idx} >= LP_N);
    assign w_s1_fwd = r_s2_valid && !r_s2_oor && (r_s2.idx == r_s1.idx);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_s1_state = '0;
        if (!w_s1_oor) begin
            w_s1_state = w_s1_fwd ? w_s3_write : r_mem[r_s1.idx];
        end
    end

    always_comb begin
        w_a = r_s2.sel_1 ? '0 : r_s2_state;
        w_b = r_s2.sel_3 ? '0 : r_s2_state;

        unique case (r_s2.sel_2)
            2'd0:    w_op1 = r_s2.pkt_1;
            2'd1:    w_op1 = r_s2.pkt_2;
            default: w_op1 = r_s2.cons_1;
        endcase

        unique case (r_s2.sel_4)
            2'd0:    w_op2 = r_s2.pkt_1;
            2'd1:    w_op2 = r_s2.pkt_2;
            default: w_op2 = r_s2.cons_2;
        endcase

        unique case (r_s2.rel)
            REL_NE:  w_pred = (w_a != w_op1);
            REL_LT:  w_pred = (w_a <  w_op1);
            REL_GT:  w_pred = (w_a >  w_op1);
            default: w_pred = (w_a == w_op1);
        endcase

        w_sum = {1'b0, w_b} + {1'b0, w_op2};
        if ((SATURATE != 0) && w_sum[W]) begin
            w_add = '1;
        end else begin
            w_add = w_sum[W-1:0];
        end

        if (r_s2_oor) begin
            w_s3_read  = '0;
            w_s3_write = '0;
        end else begin
            w_s3_read  = r_s2_state;
            w_s3_write = w_pred ? w_add : r_s2_state;
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        r_s1       <= w_in_pkt;
        r_s2       <= r_s1;
        r_s2_oor   <= w_s1_oor;
        r_s2_state <= w_s1_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            o__idx     <= '0;
            o__read    <= '0;
            o__write   <= '0;
            o__oor     <= 1'b0;
            // NOTE: the state array must reset to zero, so it is built from flops, not a RAM macro.
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                o__idx   <= r_s2.idx;
                o__read  <= w_s3_read;
                o__write <= w_s3_write;
                o__oor   <= r_s2_oor;
            end
            if (r_s2_valid && !r_s2_oor) begin
                r_mem[r_s2.idx] <= w_s3_write;
            end
        end
    end

endmodule
